rx_assemble: RTL and testbench
==============================

# rx_assemble

Receive-side word assembler for the host serial link. It collects 16 consecutive bytes from the UART receiver into one 128-bit word, first byte in the most-significant position, and writes the word into the input buffer that feeds the AES core. It mirrors the transmit-side byte serializer, so a block sent MSB-byte-first is reconstructed bit-exactly. An inter-byte timeout discards partial words so the link resynchronises after a dropped byte.

## Interface

Parameters:
- `BYTES`, 16: bytes per word; word width is 8*BYTES.
- `TIMEOUT_CYCLES`, 1_000_000: idle clk cycles after the last accepted byte before a partial word is discarded; must be ≥ 2.

Ports (`reset` is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte, valid only in the cycle `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe from the UART receiver.
- `buffer_full`  in  1  input buffer cannot accept a write this cycle.
- `buffer_write`  out  1  write strobe to the input buffer, one cycle per word.
- `d_out`  out  8*BYTES  assembled word; valid while `buffer_write`=1.
- `overrun`  out  1  one-cycle pulse: a byte arrived while in FLUSH and was dropped.
- `frame_timeout`  out  1  one-cycle pulse: a partial word was discarded.

## Operation

- States: IDLE (count=0), COLLECT (1 ≤ count < BYTES), FLUSH (word complete, waiting on buffer).
- Byte counter width is clog2(BYTES+1). Shift register width is 8*BYTES.
- IDLE/COLLECT, `rx_done`=1: shift register ← {sreg[8*BYTES-9:0], rx_data}; count+1; timeout timer cleared. After the first byte, the state is COLLECT.
- When the byte that makes count == BYTES is accepted, the next state is FLUSH. `d_out` equals the shift register; byte k (0-based arrival order) sits at bits [8*BYTES-1-8k -: 8].
- FLUSH: `buffer_write` = !`buffer_full` (combinational from state and `buffer_full`). In the cycle `buffer_write`=1, next state is IDLE, count ← 0, and the shift register is left as is. While `buffer_full`=1, the block stays in FLUSH and holds `d_out` stable.
- FLUSH with `rx_done`=1: the byte is dropped and `overrun` pulses the next cycle. This applies even if `buffer_write` is also 1 that cycle.
- Timeout: in COLLECT only, the timer increments each cycle without `rx_done`. When it reaches TIMEOUT_CYCLES-1: state → IDLE, count ← 0, `frame_timeout` pulses the next cycle. The timer does not run in IDLE or FLUSH.
- `rx_done` in the same cycle as timer expiry: the byte wins. It is accepted, the timer clears, and no timeout occurs.

## Timing

- Reset values: state IDLE, count 0, shift register 0, timer 0. Outputs: `buffer_write` 0, `d_out` 0, `overrun` 0, `frame_timeout` 0.
- Asserting reset mid-word or in FLUSH discards all state immediately. No write is issued after reset.
- Latency: 16th `rx_done` at cycle N → `buffer_write` at N+1 if `buffer_full`=0 at N+1. Otherwise, `buffer_write` comes in the first later cycle with `buffer_full`=0.
- `buffer_write` is never high in two consecutive cycles.
- The first byte of the next word is accepted at the earliest in the cycle after `buffer_write`.
- `overrun` and `frame_timeout` are registered, high for exactly one cycle per event.

## Structure

- Shared package `comm_pkg`:
  - `BYTES_PER_BLOCK` = 16.
  - `WORD_W` = 128.
  - State enum `rx_state_t` {IDLE, COLLECT, FLUSH}.
  - `TIMEOUT_CYCLES` default.
  - The transmit serializer uses the same constants.
- Sub-module `rx_timeout_timer`: ports clk, reset, clear, enable, expired; parameter TIMEOUT_CYCLES. All other logic lives in `rx_assemble`.

## Test plan

- Bytes 0x00..0x0F sent with gaps of 5 cycles, `buffer_full`=0 → one `buffer_write`, one cycle after the last byte, `d_out`=128'h000102030405060708090A0B0C0D0E0F.
- Same 16 bytes with `buffer_full`=1 for 20 cycles after the 16th byte → `buffer_write` in the first cycle `buffer_full`=0, `d_out` unchanged throughout.
- `buffer_full` held, then a 17th byte 0xAA → `overrun` pulses once. After release, the word is written and 0xAA is absent from the next word.
- TIMEOUT_CYCLES=50, 7 bytes then silence → `frame_timeout` pulses once. A following 16 bytes 0x10..0x1F are written as 128'h101112…1F.
- `rx_done` exactly on the timer-expiry cycle → no `frame_timeout`, byte counted. Reset asserted after 9 bytes → outputs 0, and the next 16 bytes form a clean word.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared constants and types for the host serial link receive/transmit paths.
package comm_pkg;

  localparam int unsigned BYTES_PER_BLOCK    = 16;
  localparam int unsigned WORD_W             = 128;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles and flags the cycle the
// count reaches TIMEOUT_CYCLES-1 while still enabled.
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] count;

  // Expiry is qualified by enable so an arriving byte always wins.
  assign expired = enable && (count == TMR_W'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, cleared on every accepted byte and outside COLLECT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMR_W'(1);
    end
  end

endmodule

// File: rtl/rx_assemble.sv
// Receive-side word assembler: packs BYTES received bytes MSB-byte-first
// into one word and hands it to the AES input buffer.
module rx_assemble
  import comm_pkg::*;
#(
  parameter int unsigned BYTES          = BYTES_PER_BLOCK,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  input  logic               buffer_full,
  output logic               buffer_write,
  output logic [8*BYTES-1:0] d_out,
  output logic               overrun,
  output logic               frame_timeout
);

  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);

  rx_state_t        state;
  logic [CNT_W-1:0] count;
  logic             tmr_clear;
  logic             tmr_enable;
  logic             tmr_expired;

  // The write strobe follows buffer_full in the same cycle so a word leaves
  // the instant the buffer has room.
  assign buffer_write = (state == FLUSH) && !buffer_full;

  // The timer only runs on silent COLLECT cycles.
  assign tmr_enable = (state == COLLECT) && !rx_done;
  assign tmr_clear  = (state != COLLECT) || rx_done;

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // Assembly FSM; d_out is the shift register itself and is held in FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      d_out         <= '0;
      overrun       <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      overrun       <= 1'b0;
      frame_timeout <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (rx_done) begin
            d_out <= {d_out[W-9:0], rx_data};
            count <= count + CNT_W'(1);
            state <= (count == CNT_W'(BYTES - 1)) ? FLUSH : COLLECT;
          end else if (tmr_expired) begin
            state         <= IDLE;
            count         <= '0;
            frame_timeout <= 1'b1;
          end
        end
        FLUSH: begin
          // A byte arriving here is lost even if the word leaves this cycle.
          if (rx_done) begin
            overrun <= 1'b1;
          end
          if (!buffer_full) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_assemble.sv
// Randomized and directed bench for rx_assemble against a queue-based model.
module tb_rx_assemble;

  localparam int unsigned NB  = 16;
  localparam int unsigned W   = 8 * NB;
  localparam int unsigned TMO = 50;

  logic         clk;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_done;
  logic         buffer_full;
  logic         buffer_write;
  logic [W-1:0] d_out;
  logic         overrun;
  logic         frame_timeout;

  int n_total;
  int n_bad;

  // Reference model: bytes of the word in progress, a completed word waiting
  // for buffer space, idle cycle count and pulses expected this cycle.
  logic [7:0]   q[$];
  logic [W-1:0] word_m;
  logic [W-1:0] dreg_m;
  bit           ready_m;
  int           idle_m;
  bit           ovr_m;
  bit           to_m;

  logic [W-1:0] last_wr;
  int           n_wr;

  rx_assemble #(
    .BYTES(NB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .buffer_full  (buffer_full),
    .buffer_write (buffer_write),
    .d_out        (d_out),
    .overrun      (overrun),
    .frame_timeout(frame_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ready_m = 1'b0;
    idle_m  = 0;
    ovr_m   = 1'b0;
    to_m    = 1'b0;
    dreg_m  = '0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
  task automatic step(input bit done, input logic [7:0] data, input bit full);
    bit nxt_ovr;
    bit nxt_to;
    rx_done     = done;
    rx_data     = data;
    buffer_full = full;
    @(negedge clk);
    chk("buffer_write", W'(buffer_write), W'(ready_m && !full));
    chk("d_out", d_out, dreg_m);
    chk("overrun", W'(overrun), W'(ovr_m));
    chk("frame_timeout", W'(frame_timeout), W'(to_m));
    if (buffer_write) begin
      chk("written_word", d_out, word_m);
      last_wr = d_out;
      n_wr++;
    end
    nxt_ovr = ready_m && done;
    nxt_to  = 1'b0;
    if (ready_m) begin
      if (!full) ready_m = 1'b0;
    end else if (done) begin
      q.push_back(data);
      idle_m = 0;
      dreg_m = {dreg_m[W-9:0], data};
      if (q.size() == NB) begin
        word_m = '0;
        foreach (q[k]) word_m[W-1-8*k -: 8] = q[k];
        ready_m = 1'b1;
        q.delete();
      end
    end else if (q.size() > 0) begin
      idle_m++;
      if (idle_m == TMO) begin
        q.delete();
        idle_m = 0;
        nxt_to = 1'b1;
      end
    end
    ovr_m = nxt_ovr;
    to_m  = nxt_to;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit full);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, full);
  endtask

  task automatic send(input logic [7:0] data, input int gap, input bit full);
    step(1'b1, data, full);
    idle(gap, full);
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b0;
    rx_done     = 1'b0;
    rx_data     = 8'h00;
    buffer_full = 1'b0;
    model_clear();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_buffer_write", W'(buffer_write), '0);
      chk("rst_d_out", d_out, '0);
      chk("rst_overrun", W'(overrun), '0);
      chk("rst_frame_timeout", W'(frame_timeout), '0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    int wr0;
    n_total = 0;
    n_bad   = 0;
    n_wr    = 0;
    last_wr = '0;
    word_m  = '0;
    model_clear();

    do_reset(3);

    // 0x00..0x0F with 5-cycle gaps, buffer free.
    wr0 = n_wr;
    for (int i = 0; i < 16; i++) send(8'(i), (i == 15) ? 0 : 5, 1'b0);
    idle(4, 1'b0);
    chk("word_seq0", last_wr, 128'h000102030405060708090A0B0C0D0E0F);
    chk("writes_seq0", W'(n_wr - wr0), W'(1));

    // Same word, buffer full for 20 cycles after the last byte.
    for (int i = 0; i < 16; i++) send(8'(i), (i == 15) ? 0 : 2, 1'b0);
    idle(20, 1'b1);
    idle(3, 1'b0);
    chk("word_held", last_wr, 128'h000102030405060708090A0B0C0D0E0F);

    // 17th byte while full is dropped; next word lacks it.
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    send(8'hAA, 4, 1'b1);
    idle(2, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'h50 + i), 1, 1'b0);
    idle(2, 1'b0);
    chk("word_no_aa", last_wr, 128'h505152535455565758595A5B5C5D5E5F);

    // 7 bytes then silence triggers a timeout; next word is clean.
    for (int i = 0; i < 7; i++) send(8'(8'hC0 + i), 1, 1'b0);
    idle(TMO + 10, 1'b0);
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0, 1'b0);
    idle(2, 1'b0);
    chk("word_after_to", last_wr, 128'h101112131415161718191A1B1C1D1E1F);

    // Byte lands exactly on the expiry cycle: byte wins, word completes.
    for (int i = 0; i < 3; i++) send(8'(8'h60 + i), 0, 1'b0);
    idle(TMO - 1, 1'b0);
    for (int i = 3; i < 16; i++) send(8'(8'h60 + i), 0, 1'b0);
    idle(2, 1'b0);
    chk("word_race", last_wr, 128'h606162636465666768696A6B6C6D6E6F);

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 9; i++) send(8'(8'hE0 + i), 1, 1'b0);
    do_reset(3);
    for (int i = 0; i < 16; i++) send(8'(8'h70 + i), 0, 1'b0);
    idle(2, 1'b0);
    chk("word_after_rst", last_wr, 128'h707172737475767778797A7B7C7D7E7F);

    // Reset while waiting in FLUSH.
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 0, 1'b0);
    idle(3, 1'b1);
    do_reset(2);
    idle(3, 1'b0);

    // Randomized traffic with varying byte rate and back-pressure.
    for (int seg = 0; seg < 60; seg++) begin
      int rate;
      int fprob;
      rate  = $urandom_range(0, 4);
      fprob = $urandom_range(0, 3);
      for (int c = 0; c < 80; c++) begin
        bit d;
        bit f;
        d = (rate == 0) ? ($urandom_range(0, 70) == 0) : ($urandom_range(0, rate) == 0);
        f = (fprob == 0) ? 1'b0 : ($urandom_range(0, fprob) != 0);
        step(d, 8'($urandom), f);
      end
      if ($urandom_range(0, 9) == 0) do_reset(1);
    end
    idle(TMO + 5, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
